// File: rtl/softmax_stream.sv
// Streaming row softmax: max scan, base-2 exp, restoring reciprocal, normalise.
// Define SOFTMAX_ROWCNT_EN to add the o_row_cnt output-handshake counter.
module softmax_stream #(
  parameter int N     = 32,
  parameter int IN_W  = 16,
  parameter int FRAC  = 14,
  parameter int OUT_W = 16,
  parameter int LEN_W = $clog2(N + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [N*IN_W-1:0]  i_data,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [N*OUT_W-1:0] o_data
`ifdef SOFTMAX_ROWCNT_EN
  ,
  output logic [15:0]        o_row_cnt
`endif
);

  localparam int SW      = FRAC + 1 + $clog2(N);
  localparam int EW      = FRAC + 1;
  localparam int RW      = OUT_W + 2;
  localparam int DIV_CYC = OUT_W + FRAC + 2;
  localparam int CNT_W   = $clog2(DIV_CYC + N + 1);
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
  localparam int PW      = IN_W + 17;
  localparam int MW      = EW + RW;
  localparam int SHW     = $clog2(FRAC + 1);
  localparam logic [MW-1:0] SAT_MAX = {{(MW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAX,
    S_EXP,
    S_DIV,
    S_NORM,
    S_OUT
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [IN_W-1:0]     x_q [N];
  logic [IN_W-1:0]     x_d [N];
  logic [IN_W-1:0]     m_q, m_d;
  logic [EW-1:0]       e_q [N];
  logic [EW-1:0]       e_d [N];
  logic [SW-1:0]       sum_q, sum_d;
  logic [SW-1:0]       rem_q, rem_d;
  logic [RW-1:0]       quo_q, quo_d;
  logic [OUT_W-1:0]    p_q [N];
  logic [OUT_W-1:0]    p_d [N];
  logic                o_valid_q, o_valid_d;
  logic                o_ready_q, o_ready_d;
  logic [N*OUT_W-1:0]  o_data_q, o_data_d;
`ifdef SOFTMAX_ROWCNT_EN
  logic [15:0]         row_cnt_q, row_cnt_d;
`endif

  logic [IDX_W-1:0]    lane;
  logic                active;
  logic                last_lane;
  logic                last_div;
  logic [IN_W-1:0]     x_lane;

  logic signed [IN_W:0]   exp_dif;
  logic signed [PW-1:0]   exp_prod;
  logic signed [PW-1:0]   exp_t;
  logic signed [PW-1:0]   exp_k;
  logic signed [PW-1:0]   exp_s;
  logic [FRAC-1:0]        exp_f;
  logic [EW-1:0]          exp_e;

  logic [SW:0]            div_sh;
  logic                   div_ge;

  logic [MW-1:0]          nrm_prod;
  logic [MW-1:0]          nrm_shift;
  logic [OUT_W-1:0]       nrm_val;

  always_comb begin
    lane      = cnt_q[IDX_W-1:0];
    active    = 32'(cnt_q) < 32'(len_q);
    last_lane = (cnt_q == CNT_W'(N - 1));
    last_div  = (cnt_q == CNT_W'(DIV_CYC - 1));
    x_lane    = x_q[lane];
  end

  // exp(d) evaluated as 2^(d*log2e): integer part shifts, fraction is a linear mantissa
  always_comb begin
    exp_dif  = {x_lane[IN_W-1], x_lane} - {m_q[IN_W-1], m_q};
    exp_prod = PW'(exp_dif) * PW'(23637);
    exp_t    = exp_prod >>> 14;
    exp_k    = exp_t >>> FRAC;
    exp_f    = exp_t[FRAC-1:0];
    exp_s    = -exp_k;
    exp_e    = (exp_s > PW'(FRAC)) ? '0 : ({1'b1, exp_f} >> exp_s[SHW-1:0]);
  end

  // Dividend is a single 1 in its MSB, so only the first iteration shifts in a 1
  always_comb begin
    div_sh = {rem_q, (cnt_q == '0)};
    div_ge = (div_sh >= {1'b0, sum_q});
  end

  always_comb begin
    nrm_prod  = MW'(e_q[lane]) * MW'(quo_q);
    nrm_shift = nrm_prod >> (FRAC + 1);
    nrm_val   = (nrm_shift > SAT_MAX) ? '1 : nrm_shift[OUT_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    x_d      = x_q;
    m_d      = m_q;
    e_d      = e_q;
    sum_d    = sum_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    p_d      = p_q;
    o_data_d = o_data_q;

    case (state_q)
      S_IDLE: begin
        if (i_valid && o_ready_q) begin
          for (int unsigned i = 0; i < N; i++) begin
            x_d[i] = i_data[i*IN_W +: IN_W];
          end
          len_d   = ((i_len == '0) || (i_len > LEN_W'(N))) ? LEN_W'(N) : i_len;
          cnt_d   = '0;
          sum_d   = '0;
          rem_d   = '0;
          quo_d   = '0;
          state_d = S_MAX;
        end
      end
      S_MAX: begin
        if (cnt_q == '0) begin
          m_d = x_lane;
        end else if (active && ($signed(x_lane) > $signed(m_q))) begin
          m_d = x_lane;
        end
        cnt_d = cnt_q + 1'b1;
        if (last_lane) begin
          cnt_d   = '0;
          state_d = S_EXP;
        end
      end
      S_EXP: begin
        e_d[lane] = active ? exp_e : '0;
        sum_d     = sum_q + SW'(e_d[lane]);
        cnt_d     = cnt_q + 1'b1;
        if (last_lane) begin
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d = div_ge ? SW'(div_sh - {1'b0, sum_q}) : div_sh[SW-1:0];
        quo_d = {quo_q[RW-2:0], div_ge};
        cnt_d = cnt_q + 1'b1;
        if (last_div) begin
          cnt_d   = '0;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        p_d[lane] = active ? nrm_val : '0;
        cnt_d     = cnt_q + 1'b1;
        if (last_lane) begin
          cnt_d   = '0;
          for (int unsigned i = 0; i < N; i++) begin
            o_data_d[i*OUT_W +: OUT_W] = p_d[i];
          end
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    o_valid_d = (state_d == S_OUT);
    o_ready_d = (state_d == S_IDLE);
  end

`ifdef SOFTMAX_ROWCNT_EN
  always_comb begin
    row_cnt_d = row_cnt_q;
    if (o_valid_q && i_ready) begin
      row_cnt_d = row_cnt_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      m_q       <= '0;
      sum_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      o_valid_q <= 1'b0;
      o_ready_q <= 1'b0;
      o_data_q  <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        x_q[i] <= '0;
        e_q[i] <= '0;
        p_q[i] <= '0;
      end
`ifdef SOFTMAX_ROWCNT_EN
      row_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      m_q       <= m_d;
      sum_q     <= sum_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      o_valid_q <= o_valid_d;
      o_ready_q <= o_ready_d;
      o_data_q  <= o_data_d;
      x_q       <= x_d;
      e_q       <= e_d;
      p_q       <= p_d;
`ifdef SOFTMAX_ROWCNT_EN
      row_cnt_q <= row_cnt_d;
`endif
    end
  end

  assign o_valid = o_valid_q;
  assign o_ready = o_ready_q;
  assign o_data  = o_data_q;
`ifdef SOFTMAX_ROWCNT_EN
  assign o_row_cnt = row_cnt_q;
`endif

endmodule
